// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared SPI definitions for the SD-card tx/rx paths
//   state_t   : serializer FSM states
//   MOSI_IDLE : level driven on MOSI outside a byte
//   SPI_CPOL/SPI_CPHA : SPI mode 0 constants
package sd_spi_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, TAIL} state_t;
  localparam logic MOSI_IDLE = 1'b1;
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: phase divider, ticks phase_end every CLK_DIV cycles
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart the phase count from zero
//   phase_end : high on the final cycle of each CLK_DIV-cycle phase
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic phase_end
);
  localparam int W = $clog2(CLK_DIV) + 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  logic [W-1:0] cnt;
  assign phase_end = cnt == LAST;
  always_ff @(posedge clk)
    cnt <= (rst | clr | phase_end) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sd_spi_tx.sv
// sd_spi_tx: pops bytes from tx_fifo and shifts them MSB-first onto SPI mode 0
//   clk, rst            : clock, synchronous active-high reset
//   enable              : permission to start/continue transmitting
//   fifo_empty/read_data: FWFT tx_fifo head; read_enable pops it
//   sclk, mosi, cs_n    : SPI bus
//   busy                : high whenever not idle
//   byte_done           : one-cycle pulse on the last cycle of each byte
module sd_spi_tx
  import sd_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_enable,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  byte_done
);
  localparam int BW = $clog2(DATA_WIDTH);
  state_t state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0] bit_cnt;
  logic phase_end, last_edge;
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(clk),
    .rst(rst),
    .clr(read_enable | (state == IDLE)),
    .phase_end(phase_end)
  );
  assign last_edge = (state == HIGH) && (bit_cnt == '0) && phase_end;
  // The next byte is popped on the last edge of the current one so bytes stream gap-free
  assign read_enable = ~rst & enable & ~fifo_empty & ((state == IDLE) | last_edge);
  assign byte_done = last_edge;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      sclk <= SPI_CPOL;
      mosi <= MOSI_IDLE;
      cs_n <= 1'b1;
      busy <= 1'b0;
    end else if (read_enable) begin
      state <= LOW;
      shreg <= read_data;
      bit_cnt <= BW'(DATA_WIDTH - 1);
      sclk <= SPI_CPOL;
      mosi <= read_data[DATA_WIDTH-1];
      cs_n <= 1'b0;
      busy <= 1'b1;
    end else if (phase_end)
      case (state)
        LOW: begin
          state <= HIGH;
          sclk <= ~SPI_CPOL;
        end
        HIGH: begin
          sclk <= SPI_CPOL;
          if (bit_cnt != '0) begin
            state <= LOW;
            shreg <= shreg << 1;
            bit_cnt <= bit_cnt - 1'b1;
            mosi <= shreg[DATA_WIDTH-2];
          end else begin
            state <= TAIL;
            mosi <= MOSI_IDLE;
          end
        end
        TAIL: begin
          state <= IDLE;
          cs_n <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
endmodule
